// File: rtl/set_ctrl_pkg.sv
// Shared types and BCD helpers for the alarm-clock set controller.
package set_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_RUN    = 3'd0,
    ST_T_HOUR = 3'd1,
    ST_T_MIN  = 3'd2,
    ST_A_HOUR = 3'd3,
    ST_A_MIN  = 3'd4
  } state_e;

  localparam logic [7:0] HOUR_LO = 8'h01;
  localparam logic [7:0] HOUR_HI = 8'h12;
  localparam logic [7:0] MIN_HI  = 8'h59;

  // MODE walks the fields in a fixed ring.
  function automatic state_e next_state(input state_e s);
    case (s)
      ST_RUN:    return ST_T_HOUR;
      ST_T_HOUR: return ST_T_MIN;
      ST_T_MIN:  return ST_A_HOUR;
      ST_A_HOUR: return ST_A_MIN;
      default:   return ST_RUN;
    endcase
  endfunction

  // Valid BCD in 01..12; anything else loads as the field minimum.
  function automatic logic [7:0] clamp_hour(input logic [7:0] v);
    if (v[3:0] <= 4'd9 && v >= HOUR_LO && v <= HOUR_HI) return v;
    return HOUR_LO;
  endfunction

  function automatic logic [7:0] clamp_min(input logic [7:0] v);
    if (v[7:4] <= 4'd5 && v[3:0] <= 4'd9) return v;
    return 8'h00;
  endfunction

  // Operands are always in range because every load passes through clamp_hour.
  function automatic logic [7:0] bcd_step_hour(input logic [7:0] val, input logic up);
    logic [3:0] hi_inc, hi_dec;
    hi_inc = val[7:4] + 4'd1;
    hi_dec = val[7:4] - 4'd1;
    if (up) begin
      if (val == HOUR_HI)      return HOUR_LO;
      if (val[3:0] == 4'd9)    return {hi_inc, 4'd0};
      return val + 8'd1;
    end
    if (val == HOUR_LO)        return HOUR_HI;
    if (val[3:0] == 4'd0)      return {hi_dec, 4'd9};
    return val - 8'd1;
  endfunction

  function automatic logic [7:0] bcd_step_min(input logic [7:0] val, input logic up);
    logic [3:0] hi_inc, hi_dec;
    hi_inc = val[7:4] + 4'd1;
    hi_dec = val[7:4] - 4'd1;
    if (up) begin
      if (val == MIN_HI)       return 8'h00;
      if (val[3:0] == 4'd9)    return {hi_inc, 4'd0};
      return val + 8'd1;
    end
    if (val == 8'h00)          return MIN_HI;
    if (val[3:0] == 4'd0)      return {hi_dec, 4'd9};
    return val - 8'd1;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// One push button: 2-FF synchronizer, stability counter, one-cycle press pulse.
// With AUTO_REPEAT_EN defined, a held key also emits repeat pulses; an instance
// with REPEAT_DELAY = 0 never repeats.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_CYCLES   = 5000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic press
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic          sync1_q, sync1_d, sync2_q, sync2_d;
  logic          db_q, db_d, press_q, press_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Level flips after DEBOUNCE_CYCLES consecutive differing samples; any agreeing sample restarts.
  always_comb begin
    sync1_d = key_n;
    sync2_d = sync1_q;
    db_d    = db_q;
    cnt_d   = '0;
    press_d = 1'b0;
    if (sync2_q != db_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
        db_d    = sync2_q;
        press_d = ~sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Debounce state; released (1) out of reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      db_q    <= 1'b1;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      db_q    <= db_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

`ifdef AUTO_REPEAT_EN
  localparam int RW = $clog2(REPEAT_DELAY + 2);

  logic [RW-1:0] rcnt_q, rcnt_d;
  logic          rep_fire;

  // rcnt counts cycles since the press pulse; after a fire it is rewound so
  // the next fire lands REPEAT_CYCLES later.
  always_comb begin
    rep_fire = (REPEAT_DELAY != 0) && !db_q && (rcnt_q == RW'(REPEAT_DELAY));
    rcnt_d   = '0;
    if (!db_q) rcnt_d = rep_fire ? RW'(REPEAT_DELAY - REPEAT_CYCLES + 1) : rcnt_q + 1'b1;
  end

  // Repeat counter state.
  always_ff @(posedge clk) begin
    if (!rst_n) rcnt_q <= '0;
    else        rcnt_q <= rcnt_d;
  end

  assign press = press_q | rep_fire;
`else
  assign press = press_q;
`endif

endmodule

// File: rtl/set_controller.sv
// Alarm-clock set front end: four debounced keys, field-select FSM, BCD edit
// register and the SET/SW_IN load strobe. Optional macro: AUTO_REPEAT_EN.
module set_controller
  import set_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_CYCLES   = 5000000
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       KEY_MODE,
  input  logic       KEY_UP,
  input  logic       KEY_DOWN,
  input  logic       KEY_COMMIT,
  input  logic [7:0] CUR_HOUR,
  input  logic [7:0] CUR_MIN,
  input  logic [7:0] CUR_A_HOUR,
  input  logic [7:0] CUR_A_MIN,
  output logic       TS_STATE,
  output logic       AS_STATE,
  output logic       SWITCH,
  output logic       SET,
  output logic [7:0] SW_IN
);

  logic       mode_p, up_p, down_p, commit_p;
  state_e     state_q, state_d, nxt;
  logic [7:0] val_q, val_d;
  logic       set_n_q, set_n_d;
  logic       is_min;

  // MODE and COMMIT never auto-repeat.
  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .REPEAT_DELAY(0), .REPEAT_CYCLES(1))
    u_mode   (.clk(CLK), .rst_n(RST_N), .key_n(KEY_MODE),   .press(mode_p));
  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_CYCLES(REPEAT_CYCLES))
    u_up     (.clk(CLK), .rst_n(RST_N), .key_n(KEY_UP),     .press(up_p));
  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_CYCLES(REPEAT_CYCLES))
    u_down   (.clk(CLK), .rst_n(RST_N), .key_n(KEY_DOWN),   .press(down_p));
  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .REPEAT_DELAY(0), .REPEAT_CYCLES(1))
    u_commit (.clk(CLK), .rst_n(RST_N), .key_n(KEY_COMMIT), .press(commit_p));

  assign is_min = (state_q == ST_T_MIN) || (state_q == ST_A_MIN);

  // Priority MODE > COMMIT > UP/DOWN; edits are ignored in RUN and dropped on leaving a field.
  always_comb begin
    state_d = state_q;
    val_d   = val_q;
    set_n_d = 1'b1;
    nxt     = next_state(state_q);
    if (mode_p) begin
      state_d = nxt;
      case (nxt)
        ST_T_HOUR: val_d = clamp_hour(CUR_HOUR);
        ST_T_MIN:  val_d = clamp_min(CUR_MIN);
        ST_A_HOUR: val_d = clamp_hour(CUR_A_HOUR);
        ST_A_MIN:  val_d = clamp_min(CUR_A_MIN);
        default:   val_d = val_q;
      endcase
    end else if (state_q != ST_RUN) begin
      if (commit_p)           set_n_d = 1'b0;
      else if (up_p ^ down_p) val_d = is_min ? bcd_step_min(val_q, up_p) : bcd_step_hour(val_q, up_p);
    end
  end

  // FSM, edit register and SET strobe.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= ST_RUN;
      val_q   <= 8'h00;
      set_n_q <= 1'b1;
    end else begin
      state_q <= state_d;
      val_q   <= val_d;
      set_n_q <= set_n_d;
    end
  end

  assign TS_STATE = (state_q == ST_T_HOUR) || (state_q == ST_T_MIN);
  assign AS_STATE = (state_q == ST_A_HOUR) || (state_q == ST_A_MIN);
  assign SWITCH   = is_min;
  assign SET      = set_n_q;
  assign SW_IN    = val_q;

endmodule

// File: tb/tb_set_controller.sv
// Directed bench for set_controller with DEBOUNCE_CYCLES = 4.
module tb_set_controller;

  localparam int D = 4;
  localparam logic [3:0] KM = 4'b1000, KU = 4'b0100, KD = 4'b0010, KC = 4'b0001;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic       KEY_MODE, KEY_UP, KEY_DOWN, KEY_COMMIT;
  logic [7:0] CUR_HOUR, CUR_MIN, CUR_A_HOUR, CUR_A_MIN;
  logic       TS_STATE, AS_STATE, SWITCH, SET;
  logic [7:0] SW_IN;

  int n_cmp = 0, n_err = 0, set_lows = 0;

  always #5 CLK = ~CLK;

  set_controller #(.DEBOUNCE_CYCLES(D), .REPEAT_DELAY(8), .REPEAT_CYCLES(4)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .KEY_MODE(KEY_MODE), .KEY_UP(KEY_UP), .KEY_DOWN(KEY_DOWN), .KEY_COMMIT(KEY_COMMIT),
    .CUR_HOUR(CUR_HOUR), .CUR_MIN(CUR_MIN), .CUR_A_HOUR(CUR_A_HOUR), .CUR_A_MIN(CUR_A_MIN),
    .TS_STATE(TS_STATE), .AS_STATE(AS_STATE), .SWITCH(SWITCH), .SET(SET), .SW_IN(SW_IN)
  );

  always @(negedge CLK) if (RST_N === 1'b1 && SET === 1'b0) set_lows++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      $error("compare %s", tag);
    end
  endtask

  task automatic flags(input string tag, input logic [2:0] exp);
    chk(tag, {29'd0, TS_STATE, AS_STATE, SWITCH}, {29'd0, exp});
  endtask

  task automatic drive(input logic [3:0] m);
    {KEY_MODE, KEY_UP, KEY_DOWN, KEY_COMMIT} = ~m;
  endtask

  // Press, hold long enough for the pulse, release, let the release settle.
  task automatic tap(input logic [3:0] m);
    @(posedge CLK); #1 drive(m);
    repeat (D + 4) @(posedge CLK);
    #1 drive(4'b0);
    repeat (D + 4) @(posedge CLK);
    @(negedge CLK);
  endtask

  initial begin
    int lat, lows, k;
    logic [7:0] v;
    RST_N = 1'b0; drive(4'b0);
    CUR_HOUR = 8'h12; CUR_MIN = 8'h59; CUR_A_HOUR = 8'h07; CUR_A_MIN = 8'h30;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    flags("reset_flags", 3'b000);
    chk("reset_set", {31'd0, SET}, 32'd1);
    chk("reset_swin", {24'd0, SW_IN}, 32'h00);
    @(posedge CLK); #1 RST_N = 1'b1;

    // 3-cycle MODE glitch: shorter than the debounce window
    @(posedge CLK); #1 drive(KM);
    repeat (3) @(posedge CLK);
    #1 drive(4'b0);
    repeat (D + 6) @(posedge CLK);
    @(negedge CLK);
    flags("glitch_flags", 3'b000);

    // MODE held from cycle 0: state visible at cycle D+3
    @(posedge CLK); #1 drive(KM);
    lat = -1;
    for (int i = 0; i < D + 9; i++) begin
      @(negedge CLK);
      if (lat < 0 && TS_STATE === 1'b1) lat = i;
    end
    chk("mode_latency", lat, D + 3);
    @(posedge CLK); #1 drive(4'b0);
    repeat (D + 4) @(posedge CLK);
    @(negedge CLK);
    flags("t_hour_flags", 3'b100);
    chk("t_hour_load", {24'd0, SW_IN}, 32'h12);
    tap(KU); chk("hour_up_wrap", {24'd0, SW_IN}, 32'h01);
    tap(KD); chk("hour_dn_wrap", {24'd0, SW_IN}, 32'h12);
    tap(KD); chk("hour_dn", {24'd0, SW_IN}, 32'h11);

    // COMMIT: exactly one SET-low cycle carrying the edit value
    @(posedge CLK); #1 drive(KC);
    lows = 0; v = 8'hxx;
    for (int i = 0; i < D + 6; i++) begin
      @(negedge CLK);
      if (SET === 1'b0) begin lows++; v = SW_IN; end
    end
    @(posedge CLK); #1 drive(4'b0);
    repeat (D + 4) @(posedge CLK);
    @(negedge CLK);
    chk("commit_width", lows, 1);
    chk("commit_value", {24'd0, v}, 32'h11);
    flags("commit_state", 3'b100);

    tap(KM); flags("t_min_flags", 3'b101);
    chk("t_min_load", {24'd0, SW_IN}, 32'h59);
    tap(KU); chk("min_up_wrap", {24'd0, SW_IN}, 32'h00);
    tap(KD); chk("min_dn_wrap", {24'd0, SW_IN}, 32'h59);
    tap(KM); flags("a_hour_flags", 3'b010);
    chk("a_hour_load", {24'd0, SW_IN}, 32'h07);
    tap(KM); flags("a_min_flags", 3'b011);
    chk("a_min_load", {24'd0, SW_IN}, 32'h30);
    tap(KM); flags("run_flags", 3'b000);
    chk("no_set_pulse", set_lows, 1);
    tap(KU); chk("run_up_ignored", {24'd0, SW_IN}, 32'h30);
    tap(KC); chk("run_commit_ignored", set_lows, 1);

    // out-of-range hour load and BCD carry/borrow
    CUR_HOUR = 8'h13; CUR_MIN = 8'h09;
    tap(KM); chk("hour_clamp", {24'd0, SW_IN}, 32'h01);
    tap(KD); chk("hour_dn_01", {24'd0, SW_IN}, 32'h12);
    tap(KM); chk("t_min_09", {24'd0, SW_IN}, 32'h09);
    tap(KU); chk("min_carry", {24'd0, SW_IN}, 32'h10);
    tap(KD); chk("min_borrow", {24'd0, SW_IN}, 32'h09);
    tap(KM); tap(KM); tap(KM); flags("back_to_run", 3'b000);
    CUR_HOUR = 8'h09; CUR_MIN = 8'h5A;
    tap(KM); chk("t_hour_09", {24'd0, SW_IN}, 32'h09);
    tap(KU); chk("hour_carry", {24'd0, SW_IN}, 32'h10);
    tap(KD); chk("hour_borrow", {24'd0, SW_IN}, 32'h09);
    tap(KM); chk("min_clamp", {24'd0, SW_IN}, 32'h00);

    // same-cycle pulses
    tap(KM | KU); flags("mode_up_flags", 3'b010);
    chk("mode_up_value", {24'd0, SW_IN}, 32'h07);
    tap(KU | KD); chk("up_down_none", {24'd0, SW_IN}, 32'h07);
    tap(KC | KU); chk("commit_up_value", {24'd0, SW_IN}, 32'h07);
    chk("commit_up_set", set_lows, 2);

    // reset mid-edit
    @(posedge CLK); #1 RST_N = 1'b0;
    @(posedge CLK); #1 RST_N = 1'b1;
    @(negedge CLK);
    flags("rst_edit_flags", 3'b000);
    chk("rst_edit_set", {31'd0, SET}, 32'd1);
    repeat (4) @(negedge CLK);
    chk("rst_edit_no_set", set_lows, 2);

`ifdef AUTO_REPEAT_EN
    CUR_HOUR = 8'h01;
    tap(KM); chk("rep_load", {24'd0, SW_IN}, 32'h01);
    @(posedge CLK); #1 drive(KU);
    k = 0;
    @(negedge CLK);
    while (SW_IN !== 8'h02 && k < 20) begin @(negedge CLK); k++; end
    chk("rep_first_step", {31'd0, k < 20}, 32'd1);
    repeat (7) @(negedge CLK); chk("rep_before", {24'd0, SW_IN}, 32'h02);
    @(negedge CLK);            chk("rep_delay", {24'd0, SW_IN}, 32'h03);
    repeat (4) @(negedge CLK); chk("rep_period", {24'd0, SW_IN}, 32'h04);
    @(posedge CLK); #1 drive(4'b0);
    repeat (20) @(posedge CLK);
    @(negedge CLK);
    chk("rep_release", {24'd0, SW_IN}, 32'h05);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/set_controller.md
# set_controller

User-input front end for the alarm clock. Debounces four push buttons and runs a mode FSM that selects the field being edited. Holds an editable BCD value with range-checked up/down stepping, and drives the set interface of the timekeeping core: TS_STATE, AS_STATE, SWITCH, SET and SW_IN. The core loads SW_IN while SET is low.

## Interface
- DEBOUNCE_CYCLES, 1000000: consecutive stable synchronized samples needed to accept a key level (20 ms at 50 MHz).
- REPEAT_DELAY, 25000000: hold time before the first auto-repeat step. Used only with AUTO_REPEAT_EN.
- REPEAT_CYCLES, 5000000: interval between auto-repeat steps. Used only with AUTO_REPEAT_EN.
- CLK  in  1  system clock, 50 MHz. This is the only clock.
- RST_N  in  1  synchronous reset, active-low.
- KEY_MODE, KEY_UP, KEY_DOWN, KEY_COMMIT  in  1 each  raw push buttons, active-low, asynchronous to CLK.
- CUR_HOUR, CUR_MIN  in  8  current time from the core, packed BCD.
- CUR_A_HOUR, CUR_A_MIN  in  8  current alarm time from the core, packed BCD.
- TS_STATE  out  1  high while a time field is being edited.
- AS_STATE  out  1  high while an alarm field is being edited.
- SWITCH  out  1  selects the field: 1 = minutes, 0 = hours.
- SET  out  1  active-low commit strobe, low for exactly one cycle.
- SW_IN  out  8  edit value, packed BCD, driven continuously.

## Operation
- **Key path:** 2-FF synchronizer, then a stability counter, then the debounced level.
  - The debounced level changes only after DEBOUNCE_CYCLES consecutive equal samples.
  - A press pulse is one cycle long, on a debounced 1→0 transition.
- **FSM states:** RUN, T_HOUR, T_MIN, A_HOUR, A_MIN.
  - A MODE press advances RUN→T_HOUR→T_MIN→A_HOUR→A_MIN→RUN.
- **Outputs per state:**
  - TS_STATE is 1 in T_*.
  - AS_STATE is 1 in A_*.
  - SWITCH is 1 in *_MIN.
  - All three are 0 in RUN.
- **Entering a field:** the edit register loads the matching CUR_* input, sampled in the cycle of the MODE pulse.
- **Ignored in RUN:** UP, DOWN and COMMIT. SW_IN holds its last value.
- **Hour step:** range 8'h01..8'h12.
  - UP on 12 gives 01; DOWN on 01 gives 12.
  - 09+1 gives 10 (BCD carry); 10−1 gives 09 (BCD borrow).
- **Minute step:** range 8'h00..8'h59, wrapping in both directions.
  - Ones digit 9+1 gives 0 with a tens carry; ones digit 0−1 gives 9 with a tens borrow.
- **Out-of-range load:** a loaded CUR_* value that is out of range or not valid BCD is clamped to the field minimum (01 for hours, 00 for minutes) on load.
- **COMMIT:** SET goes low for one cycle with SW_IN equal to the edit value. The state is unchanged.
- **Leaving a field:** leaving without COMMIT discards the edit.
- **Priority among same-cycle pulses:** MODE > COMMIT > UP/DOWN. Lower-priority pulses in that cycle are dropped. UP and DOWN together produce no step.

## Timing
- **Reset values:**
  - State RUN.
  - TS_STATE = 0, AS_STATE = 0, SWITCH = 0.
  - SET = 1, SW_IN = 8'h00.
  - Debounced levels = 1 (released); all counters 0.
- **Reset during edit:** returns to RUN the next cycle. No SET pulse is issued.
- **Key latency:** a raw key held low from cycle 0 gives a press pulse in cycle DEBOUNCE_CYCLES+2. The resulting state or SW_IN change is visible at cycle DEBOUNCE_CYCLES+3.
- **Commit latency:** SET is low in the cycle after the COMMIT pulse. SW_IN is stable in that cycle and in the cycle before it.
- **Glitches:** a glitch shorter than DEBOUNCE_CYCLES restarts the counter and produces no pulse.
- **Held key:** produces one pulse. Its release produces no pulse.

## Configuration
- **AUTO_REPEAT_EN defined:**
  - UP or DOWN held past REPEAT_DELAY cycles after its press pulse emits extra step pulses every REPEAT_CYCLES until release.
  - Repeat pulses obey the same priority rules as press pulses.
  - MODE and COMMIT never repeat.
- **AUTO_REPEAT_EN undefined:** one step per press. The repeat counters are not built; REPEAT_* are unused.

## Structure
- **Package `set_ctrl_pkg`:**
  - State enum.
  - Constants HOUR_LO = 8'h01, HOUR_HI = 8'h12, MIN_HI = 8'h59.
  - Functions bcd_step_hour(val, up) and bcd_step_min(val, up).
- **Sub-module `key_debounce`:** synchronizer, stability counter and press-pulse output, parameterized by DEBOUNCE_CYCLES. Instantiated four times.

## Test plan
Bench uses DEBOUNCE_CYCLES = 4.
- Reset → RUN, TS_STATE = 0, AS_STATE = 0, SWITCH = 0, SET = 1, SW_IN = 00. Hold KEY_MODE low for 3 cycles → no state change.
- MODE pressed with CUR_HOUR = 12 → T_HOUR, SW_IN = 12. UP → 01. DOWN twice → 11. COMMIT → SET low for exactly 1 cycle with SW_IN = 11.
- Advance to T_MIN with CUR_MIN = 59 → UP gives 00. DOWN gives 59. From 09, UP gives 10.
- Four further MODE presses → T_MIN→A_HOUR→A_MIN→RUN. TS_STATE/AS_STATE/SWITCH follow 10/1, 01/0, 01/1, 00/0. No SET pulse.
- MODE and UP pulses in the same cycle → only the state advance occurs. UP and DOWN together → value unchanged. RST_N low mid-edit → RUN, SET stays 1.
- With AUTO_REPEAT_EN, REPEAT_DELAY = 8, REPEAT_CYCLES = 4: hold UP in T_HOUR starting at 01 → 02, then 03 eight cycles later, then +1 every 4 cycles until release.
